// File: rtl/CPU_Defines.sv
// Shared CPU definitions: MIPS-style exception codes and the fetch-queue entry layout.
package CPU_Defines;

    localparam logic [4:0] EXCCODE_INT  = 5'd0;
    localparam logic [4:0] EXCCODE_ADEL = 5'd4;
    localparam logic [4:0] EXCCODE_ADES = 5'd5;
    localparam logic [4:0] EXCCODE_SYS  = 5'd8;
    localparam logic [4:0] EXCCODE_BP   = 5'd9;
    localparam logic [4:0] EXCCODE_RI   = 5'd10;
    localparam logic [4:0] EXCCODE_OV   = 5'd12;
    // Reserved encoding that no architectural exception uses.
    localparam logic [4:0] EXCCODE_NONE = 5'd31;

    typedef struct packed {
        logic [31:0] PC;
        logic [31:0] Instr;
        logic [4:0]  ExcCode;
    } fetch_entry_t;

endpackage

// File: rtl/if_id_inst_queue.sv
// IF->ID instruction queue: circular buffer with show-ahead head, wrap-bit pointers
// and a synchronous flush for branch redirects and exceptions.
module if_id_inst_queue
    import CPU_Defines::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             IF_Valid,
    output logic             IF_Ready,
    input  logic [31:0]      IF_PC,
    input  logic [31:0]      IF_Instr,
    input  logic [4:0]       IF_ExcCode,
    output logic             ID_Valid,
    input  logic             ID_Ready,
    output logic [31:0]      ID_PC,
    output logic [31:0]      ID_Instr,
    output logic [15:0]      ID_Imm16,
    output logic [4:0]       ID_ExcCode,
    input  logic             ID_Flush,
    output logic [PTR_W:0]   Q_Count
);

    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    fetch_entry_t   r_mem [DEPTH];
    logic [PTR_W:0] r_head;
    logic [PTR_W:0] r_tail;
    logic           w_empty;
    logic           w_full;
    logic           w_push;
    logic           w_pop;
    fetch_entry_t   w_head_entry;

    assign w_empty = (r_head == r_tail);
    assign w_full  = (r_head[PTR_W] != r_tail[PTR_W]) &&
                     (r_head[PTR_W-1:0] == r_tail[PTR_W-1:0]);

    // Ready depends on state only, so a full queue never passes a word through.
    assign IF_Ready = !w_full;
    assign ID_Valid = !w_empty;
    assign w_push   = IF_Valid && !w_full;
    assign w_pop    = ID_Valid && ID_Ready;

    // Storage write; the array is left unreset because reads are masked while empty.
    always_ff @(posedge clk) begin
        if (w_push && !ID_Flush) begin
            r_mem[r_tail[PTR_W-1:0]] <= '{PC: IF_PC, Instr: IF_Instr, ExcCode: IF_ExcCode};
        end
    end

    // Head/tail pointers; flush beats any same-cycle push or pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (ID_Flush) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_ONE;
            end
        end
    end

    // Show-ahead head read, forced to a NOP with no exception when empty.
    always_comb begin
        w_head_entry = '{PC: 32'h0, Instr: 32'h0, ExcCode: EXCCODE_NONE};
        if (!w_empty) begin
            w_head_entry = r_mem[r_head[PTR_W-1:0]];
        end else begin
            w_head_entry = '{PC: 32'h0, Instr: 32'h0, ExcCode: EXCCODE_NONE};
        end
    end

    assign ID_PC      = w_head_entry.PC;
    assign ID_Instr   = w_head_entry.Instr;
    assign ID_ExcCode = w_head_entry.ExcCode;
    assign ID_Imm16   = w_head_entry.Instr[15:0];
    assign Q_Count    = r_tail - r_head;

endmodule

// File: tb/tb_if_id_inst_queue.sv
// Directed bench for if_id_inst_queue: an occupancy model plus an expected-entry
// scoreboard checks every cycle's outputs against what the queue should hold.
module tb_if_id_inst_queue;
    import CPU_Defines::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk;
    logic             resetn;
    logic             IF_Valid;
    logic             IF_Ready;
    logic [31:0]      IF_PC;
    logic [31:0]      IF_Instr;
    logic [4:0]       IF_ExcCode;
    logic             ID_Valid;
    logic             ID_Ready;
    logic [31:0]      ID_PC;
    logic [31:0]      ID_Instr;
    logic [15:0]      ID_Imm16;
    logic [4:0]       ID_ExcCode;
    logic             ID_Flush;
    logic [PTR_W:0]   Q_Count;

    int n_cmp = 0;
    int n_err = 0;
    int model_cnt = 0;
    fetch_entry_t sb[$];
    fetch_entry_t exp_e;

    if_id_inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .resetn(resetn),
        .IF_Valid(IF_Valid), .IF_Ready(IF_Ready), .IF_PC(IF_PC),
        .IF_Instr(IF_Instr), .IF_ExcCode(IF_ExcCode),
        .ID_Valid(ID_Valid), .ID_Ready(ID_Ready), .ID_PC(ID_PC),
        .ID_Instr(ID_Instr), .ID_Imm16(ID_Imm16), .ID_ExcCode(ID_ExcCode),
        .ID_Flush(ID_Flush), .Q_Count(Q_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Check all outputs against the model, then apply one clock of stimulus.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [4:0] exc, input logic rdy, input logic fl);
        bit acc_push;
        IF_Valid = v; IF_PC = pc; IF_Instr = ins; IF_ExcCode = exc;
        ID_Ready = rdy; ID_Flush = fl;
        #1;
        chk("ID_Valid", {31'd0, ID_Valid}, {31'd0, model_cnt != 0});
        chk("IF_Ready", {31'd0, IF_Ready}, {31'd0, model_cnt != DEPTH});
        chk("Q_Count", {29'd0, Q_Count}, model_cnt);
        if (model_cnt != 0) exp_e = sb[0];
        else exp_e = '{PC: 32'h0, Instr: 32'h0, ExcCode: EXCCODE_NONE};
        chk("ID_PC", ID_PC, exp_e.PC);
        chk("ID_Instr", ID_Instr, exp_e.Instr);
        chk("ID_Imm16", {16'd0, ID_Imm16}, {16'd0, exp_e.Instr[15:0]});
        chk("ID_ExcCode", {27'd0, ID_ExcCode}, {27'd0, exp_e.ExcCode});
        acc_push = v && (model_cnt < DEPTH);
        if (fl) begin
            sb.delete();
            model_cnt = 0;
        end else begin
            if (rdy && model_cnt > 0) begin
                void'(sb.pop_front());
                model_cnt--;
            end
            if (acc_push) begin
                sb.push_back('{PC: pc, Instr: ins, ExcCode: exc});
                model_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 32'h0, 32'h0, EXCCODE_NONE, rdy, 1'b0);
    endtask

    initial begin
        resetn = 1'b0;
        IF_Valid = 1'b0; IF_PC = '0; IF_Instr = '0; IF_ExcCode = EXCCODE_NONE;
        ID_Ready = 1'b0; ID_Flush = 1'b0;
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        @(posedge clk);
        #1;

        // Reset state, single push/pop with 1-cycle latency.
        idle(1'b0);
        cycle(1'b1, 32'hBFC00000, 32'h24080005, EXCCODE_NONE, 1'b0, 1'b0);
        chk("first_imm16", {16'd0, ID_Imm16}, 32'h0000_0005);
        chk("first_count", {29'd0, Q_Count}, 32'd1);
        idle(1'b1);
        idle(1'b0);

        // Fill past full with ID stalled: 5th word refused.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 32'h80000000 + 32'(4 * i), 32'h20000000 + 32'(i), EXCCODE_NONE, 1'b0, 1'b0);
        chk("full_count", {29'd0, Q_Count}, 32'd4);
        // Push and pop together at full: only the pop happens, the push retries next cycle.
        cycle(1'b1, 32'h80000100, 32'h2000_0100, EXCCODE_NONE, 1'b1, 1'b0);
        chk("full_pop_count", {29'd0, Q_Count}, 32'd3);
        cycle(1'b1, 32'h80000100, 32'h2000_0100, EXCCODE_NONE, 1'b0, 1'b0);
        chk("refill_count", {29'd0, Q_Count}, 32'd4);
        repeat (4) idle(1'b1);
        idle(1'b0);

        // Streaming push+pop: pointers wrap several times, occupancy stays 1.
        cycle(1'b1, 32'h90000000, 32'h3400_0000, EXCCODE_NONE, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++)
            cycle(1'b1, 32'h90000000 + 32'(4 * i), 32'h3400_0000 + 32'(i), EXCCODE_NONE, 1'b1, 1'b0);
        chk("stream_count", {29'd0, Q_Count}, 32'd1);
        idle(1'b1);
        idle(1'b0);

        // Flush with 3 entries and a concurrent push+pop: everything discarded.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'hA0000000 + 32'(4 * i), 32'h2401_0000 + 32'(i), EXCCODE_NONE, 1'b0, 1'b0);
        cycle(1'b1, 32'hDEAD0000, 32'hDEAD_BEEF, EXCCODE_RI, 1'b1, 1'b1);
        chk("flush_count", {29'd0, Q_Count}, 32'd0);
        chk("flush_valid", {31'd0, ID_Valid}, 32'd0);
        cycle(1'b1, 32'hB0000000, 32'h2402_0001, EXCCODE_NONE, 1'b0, 1'b0);
        cycle(1'b1, 32'hB0000004, 32'h2402_0002, EXCCODE_NONE, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Asynchronous reset mid-cycle with 2 entries queued.
        cycle(1'b1, 32'hC0000000, 32'h2403_0001, EXCCODE_NONE, 1'b0, 1'b0);
        cycle(1'b1, 32'hC0000004, 32'h2403_0002, EXCCODE_NONE, 1'b0, 1'b0);
        IF_Valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("arst_valid", {31'd0, ID_Valid}, 32'd0);
        chk("arst_ready", {31'd0, IF_Ready}, 32'd1);
        chk("arst_count", {29'd0, Q_Count}, 32'd0);
        sb.delete();
        model_cnt = 0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 32'hBFC00380, 32'h0000_0000, EXCCODE_ADEL, 1'b0, 1'b0);
        chk("adel_exc", {27'd0, ID_ExcCode}, {27'd0, EXCCODE_ADEL});
        idle(1'b1);
        idle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/if_id_inst_queue.md
Name: if_id_inst_queue

Overview:
- Instruction queue between the IF stage and the ID stage.
- Buffers fetched words (PC, instruction, fetch exception code) so fetch can run ahead when ID stalls.
- Presents the oldest entry to ID in show-ahead form; ID_Imm16 is the instruction's low half and feeds the ID immediate extender.
- Flushed on branch redirect or exception.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), index width; the pointers carry one extra wrap bit.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- IF_Valid  in  1  fetch word valid this cycle
- IF_Ready  out  1  queue can accept a word (not full)
- IF_PC  in  32  PC of the fetched word
- IF_Instr  in  32  fetched instruction
- IF_ExcCode  in  5  fetch exception code (EXCCODE_NONE if none)
- ID_Valid  out  1  head entry valid
- ID_Ready  in  1  ID consumes the head this cycle
- ID_PC  out  32  head PC
- ID_Instr  out  32  head instruction
- ID_Imm16  out  16  ID_Instr[15:0]
- ID_ExcCode  out  5  head exception code
- ID_Flush  in  1  synchronous flush of all entries
- Q_Count  out  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Storage: circular buffer of DEPTH entries {PC, Instr, ExcCode}. Head and tail pointers are PTR_W+1 bits wide.
  - empty = (head == tail).
  - full = MSBs differ and the low PTR_W bits are equal.
- Push: IF_Valid && IF_Ready. Write the entry at tail[PTR_W-1:0], then tail += 1, wrapping modulo 2*DEPTH.
- Pop: ID_Valid && ID_Ready. head += 1, same wrap.
- IF_Ready = !full, combinational from state only; no dependence on ID_Ready, so there is no full-state pass-through.
- ID_Valid = !empty.
- ID_PC, ID_Instr and ID_ExcCode read the head entry combinationally. When empty they are forced to 0, 0 and EXCCODE_NONE (ID_Instr 0 is a NOP).
- Latency: a word pushed at edge N is visible on the ID outputs after edge N if the queue was empty. Minimum IF-to-ID latency is 1 cycle; there is no bypass path.
- Simultaneous push and pop with 0 < count < DEPTH: both take effect and count is unchanged.
- Push into empty with ID_Ready=1: the pop is not qualified because ID_Valid=0, so count becomes 1.
- Q_Count = tail - head, modulo 2*DEPTH, registered pointer difference.
- ID_Flush=1 at an edge:
  - head and tail reset to 0; same-cycle push and pop are discarded.
  - ID_Valid=0 in the following cycle.
  - Flush has priority over everything except resetn.
  - IF_Ready is not masked during a flush cycle; the word offered is dropped, and IF re-fetches from the redirected PC.
- Reset (resetn=0, asynchronous): head=tail=0, so ID_Valid=0, IF_Ready=1, Q_Count=0 and the outputs take their empty values.
  - Storage array is not reset; outputs are masked while empty.
  - Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Wrap-around: pointers roll over without loss. After any number of push/pop pairs, ordering is strictly FIFO.
- X-safety: no output depends on unwritten storage while ID_Valid=0.

Decomposition:
- Shared package (CPU_Defines): EXCCODE_NONE, the 5-bit ExcCode constants, and packed struct fetch_entry_t {PC[31:0], Instr[31:0], ExcCode[4:0]}.
- No sub-module required. The storage array and pointer logic live in this module.
- A generic sync_fifo is acceptable only if it supports a synchronous clear and a show-ahead read; otherwise keep it inline.

Test Plan:
- Reset, then push PC=0xBFC00000, Instr=0x24080005 -> next cycle ID_Valid=1, ID_Imm16=0x0005, Q_Count=1. Pop -> ID_Valid=0, ID_Instr=0.
- Hold ID_Ready=0 and push 5 words with DEPTH=4 -> IF_Ready drops after the 4th push and the 5th is not accepted. Q_Count=4. Pops return PCs in order 0x..00, 0x..04, 0x..08, 0x..0C.
- At full, assert IF_Valid and ID_Ready in the same cycle -> only the pop occurs, Q_Count 4->3. The next cycle the push is accepted, giving count 4.
- Continuous push and pop for 20 cycles, PC stepping by 4 -> pointers wrap at least twice. Output PC sequence is contiguous with no duplicates; count stays at 1.
- With 3 entries held, assert ID_Flush together with IF_Valid and ID_Ready -> next cycle Q_Count=0 and ID_Valid=0, and the offered word is absent from all later pops.
- Drop resetn asynchronously mid-clock with 2 entries queued -> ID_Valid=0 and IF_Ready=1 before the next edge. Push IF_ExcCode=4 (AdEL) after release -> ID_ExcCode=4.
